phys_reg_wakeup: RTL and testbench

- Receiving end of the EXE result broadcast (broadcast_flag/map/reg/val).
- Holds the 64-entry physical register value array and per-entry ready bits.
- Serves two issue-side operand read ports with same-cycle broadcast bypass.
- Re-emits a registered wakeup pulse to the issue queue and tracks the count of outstanding (not-ready) registers.
- Sits between EXE and the rename/issue stages.

---
 rtl/phys_reg_wakeup.sv | 169 ++++++++++++++++
 tb/tb_phys_reg_wakeup.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/phys_reg_wakeup.sv
// phys_reg_wakeup: physical register file receiving the EXE result broadcast.
// Keeps the value array and per-entry ready bits, serves two issue-side
// operand read ports with same-cycle broadcast bypass, re-emits a registered
// wakeup pulse to the issue queue, and counts outstanding (not-ready) entries.
// Entry 0 is hardwired: always ready, value 0, immune to alloc and broadcast.

module phys_reg_wakeup #(
    parameter int NUM_PREGS = 64,
    parameter int DATA_W    = 32,
    parameter int IDX_W     = $clog2(NUM_PREGS)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              broadcast_flag,
    input  logic [IDX_W-1:0]  broadcast_map,
    input  logic [4:0]        broadcast_reg,
    input  logic [DATA_W-1:0] broadcast_val,
    input  logic              alloc_flag,
    input  logic [IDX_W-1:0]  alloc_map,
    input  logic              flush,
    input  logic [IDX_W-1:0]  rd_mapA,
    input  logic [IDX_W-1:0]  rd_mapB,
    output logic [DATA_W-1:0] rd_valA,
    output logic [DATA_W-1:0] rd_valB,
    output logic              rd_readyA,
    output logic              rd_readyB,
    output logic              wakeup_flag,
    output logic [IDX_W-1:0]  wakeup_map,
    output logic [DATA_W-1:0] wakeup_val,
    output logic [IDX_W:0]    pending_count
);

    localparam logic [IDX_W-1:0]  ZERO_IDX  = {IDX_W{1'b0}};
    localparam logic [DATA_W-1:0] ZERO_VAL  = {DATA_W{1'b0}};
    localparam logic [IDX_W:0]    ZERO_CNT  = {(IDX_W+1){1'b0}};
    localparam logic [IDX_W:0]    ONE_CNT   = {{IDX_W{1'b0}}, 1'b1};
    localparam logic [IDX_W:0]    MAX_PEND  = (IDX_W+1)'(NUM_PREGS - 1);

    logic [DATA_W-1:0]    value_r [NUM_PREGS];
    logic [NUM_PREGS-1:0] ready_r;
    logic [NUM_PREGS-1:0] ready_next_s;
    logic                 wakeup_flag_r;
    logic [IDX_W-1:0]     wakeup_map_r;
    logic [DATA_W-1:0]    wakeup_val_r;
    logic [IDX_W:0]       pending_r;
    logic [IDX_W:0]       pending_next_s;
    logic                 bc_hit_s;
    logic                 al_hit_s;
    logic                 inc_s;
    logic                 dec_s;
    logic                 debug_unused_s;

    // The architectural destination is carried for debug visibility only.
    assign debug_unused_s = ^broadcast_reg;

    // Qualify broadcast/alloc events and decide the pending-count step.
    always_comb begin
        bc_hit_s = broadcast_flag && (broadcast_map != ZERO_IDX);
        // A flush discards any allocation presented in the same cycle.
        al_hit_s = alloc_flag && (alloc_map != ZERO_IDX) && !flush;
        inc_s    = al_hit_s && ready_r[alloc_map];
        // A same-map allocation re-arms the entry, so no decrement then.
        dec_s    = bc_hit_s && !ready_r[broadcast_map] &&
                   !(al_hit_s && (alloc_map == broadcast_map));
    end

    // Next ready vector: flush readies everything, alloc beats broadcast.
    always_comb begin
        ready_next_s = ready_r;
        if (flush) begin
            ready_next_s = {NUM_PREGS{1'b1}};
        end else begin
            if (bc_hit_s) begin
                ready_next_s[broadcast_map] = 1'b1;
            end else begin
                ready_next_s = ready_next_s;
            end
            if (al_hit_s) begin
                ready_next_s[alloc_map] = 1'b0;
            end else begin
                ready_next_s = ready_next_s;
            end
        end
        ready_next_s[0] = 1'b1;
    end

    // Next pending count, bounded to 0..NUM_PREGS-1.
    always_comb begin
        pending_next_s = pending_r;
        if (flush) begin
            pending_next_s = ZERO_CNT;
        end else if (inc_s && !dec_s && (pending_r < MAX_PEND)) begin
            pending_next_s = pending_r + ONE_CNT;
        end else if (dec_s && !inc_s && (pending_r > ZERO_CNT)) begin
            pending_next_s = pending_r - ONE_CNT;
        end else begin
            pending_next_s = pending_r;
        end
    end

    // Ready bits and pending count state.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ready_r   <= {NUM_PREGS{1'b1}};
            pending_r <= ZERO_CNT;
        end else begin
            ready_r   <= ready_next_s;
            pending_r <= pending_next_s;
        end
    end

    // Value array: a valid broadcast writes its result (flush does not block it).
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NUM_PREGS; i++) begin
                value_r[i] <= ZERO_VAL;
            end
        end else begin
            if (bc_hit_s) begin
                value_r[broadcast_map] <= broadcast_val;
            end
        end
    end

    // Registered single-cycle wakeup pulse, one cycle after the broadcast.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wakeup_flag_r <= 1'b0;
            wakeup_map_r  <= ZERO_IDX;
            wakeup_val_r  <= ZERO_VAL;
        end else begin
            wakeup_flag_r <= bc_hit_s;
            if (bc_hit_s) begin
                wakeup_map_r <= broadcast_map;
                wakeup_val_r <= broadcast_val;
            end
        end
    end

    // Operand read ports with same-cycle broadcast bypass; map 0 reads as ready zero.
    always_comb begin
        if (rd_mapA == ZERO_IDX) begin
            rd_valA   = ZERO_VAL;
            rd_readyA = 1'b1;
        end else if (broadcast_flag && (broadcast_map == rd_mapA)) begin
            rd_valA   = broadcast_val;
            rd_readyA = 1'b1;
        end else begin
            rd_valA   = value_r[rd_mapA];
            rd_readyA = ready_r[rd_mapA];
        end
        if (rd_mapB == ZERO_IDX) begin
            rd_valB   = ZERO_VAL;
            rd_readyB = 1'b1;
        end else if (broadcast_flag && (broadcast_map == rd_mapB)) begin
            rd_valB   = broadcast_val;
            rd_readyB = 1'b1;
        end else begin
            rd_valB   = value_r[rd_mapB];
            rd_readyB = ready_r[rd_mapB];
        end
    end

    assign wakeup_flag   = wakeup_flag_r;
    assign wakeup_map    = wakeup_map_r;
    assign wakeup_val    = wakeup_val_r;
    assign pending_count = pending_r;

endmodule

// File: tb/tb_phys_reg_wakeup.sv
// Directed self-checking bench for phys_reg_wakeup.

module tb_phys_reg_wakeup;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        broadcast_flag;
    logic [5:0]  broadcast_map;
    logic [4:0]  broadcast_reg;
    logic [31:0] broadcast_val;
    logic        alloc_flag;
    logic [5:0]  alloc_map;
    logic        flush;
    logic [5:0]  rd_mapA;
    logic [5:0]  rd_mapB;
    logic [31:0] rd_valA;
    logic [31:0] rd_valB;
    logic        rd_readyA;
    logic        rd_readyB;
    logic        wakeup_flag;
    logic [5:0]  wakeup_map;
    logic [31:0] wakeup_val;
    logic [6:0]  pending_count;

    int checks = 0;
    int errors = 0;

    phys_reg_wakeup dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .broadcast_flag(broadcast_flag),
        .broadcast_map (broadcast_map),
        .broadcast_reg (broadcast_reg),
        .broadcast_val (broadcast_val),
        .alloc_flag    (alloc_flag),
        .alloc_map     (alloc_map),
        .flush         (flush),
        .rd_mapA       (rd_mapA),
        .rd_mapB       (rd_mapB),
        .rd_valA       (rd_valA),
        .rd_valB       (rd_valB),
        .rd_readyA     (rd_readyA),
        .rd_readyB     (rd_readyB),
        .wakeup_flag   (wakeup_flag),
        .wakeup_map    (wakeup_map),
        .wakeup_val    (wakeup_val),
        .pending_count (pending_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        broadcast_flag = 1'b0;
        broadcast_map  = 6'd0;
        broadcast_reg  = 5'd0;
        broadcast_val  = 32'd0;
        alloc_flag     = 1'b0;
        alloc_map      = 6'd0;
        flush          = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rd_mapA = 6'd0;
        rd_mapB = 6'd0;
        RESET   = 1'b1;
        #2 RESET = 1'b0;
        #1;
        chk("rst_wakeup_flag", {31'd0, wakeup_flag}, 32'd0);
        chk("rst_wakeup_map", {26'd0, wakeup_map}, 32'd0);
        chk("rst_wakeup_val", wakeup_val, 32'd0);
        chk("rst_pending", {25'd0, pending_count}, 32'd0);
        step();
        RESET = 1'b1;
        step();

        // Every entry ready with value zero after reset.
        for (int i = 0; i < 64; i++) begin
            rd_mapA = 6'(i);
            rd_mapB = 6'(63 - i);
            #1;
            chk("rst_readyA", {31'd0, rd_readyA}, 32'd1);
            chk("rst_valA", rd_valA, 32'd0);
            chk("rst_readyB", {31'd0, rd_readyB}, 32'd1);
            chk("rst_valB", rd_valB, 32'd0);
        end

        // Allocate map 5.
        alloc_flag = 1'b1; alloc_map = 6'd5;
        step();
        idle_inputs();
        rd_mapA = 6'd5; rd_mapB = 6'd5;
        #1;
        chk("alloc5_readyA", {31'd0, rd_readyA}, 32'd0);
        chk("alloc5_pending", {25'd0, pending_count}, 32'd1);
        chk("alloc5_nowake", {31'd0, wakeup_flag}, 32'd0);

        // Broadcast map 5: both ports bypassed in the same cycle.
        broadcast_flag = 1'b1; broadcast_map = 6'd5; broadcast_val = 32'hDEADBEEF; broadcast_reg = 5'd7;
        #1;
        chk("byp5_valA", rd_valA, 32'hDEADBEEF);
        chk("byp5_readyA", {31'd0, rd_readyA}, 32'd1);
        chk("byp5_valB", rd_valB, 32'hDEADBEEF);
        chk("byp5_readyB", {31'd0, rd_readyB}, 32'd1);
        step();
        idle_inputs();
        #1;
        chk("wake5_flag", {31'd0, wakeup_flag}, 32'd1);
        chk("wake5_map", {26'd0, wakeup_map}, 32'd5);
        chk("wake5_val", wakeup_val, 32'hDEADBEEF);
        chk("wake5_pending", {25'd0, pending_count}, 32'd0);
        chk("stored5_valA", rd_valA, 32'hDEADBEEF);
        chk("stored5_readyA", {31'd0, rd_readyA}, 32'd1);

        // Broadcast to map 0 is ignored.
        broadcast_flag = 1'b1; broadcast_map = 6'd0; broadcast_val = 32'h1234;
        rd_mapA = 6'd0;
        #1;
        chk("map0_valA", rd_valA, 32'd0);
        chk("map0_readyA", {31'd0, rd_readyA}, 32'd1);
        step();
        idle_inputs();
        #1;
        chk("map0_nowake", {31'd0, wakeup_flag}, 32'd0);
        chk("map0_pending", {25'd0, pending_count}, 32'd0);
        chk("map0_val_after", rd_valA, 32'd0);

        // Alloc and broadcast to map 9 together: alloc wins, wakeup still fires.
        alloc_flag = 1'b1; alloc_map = 6'd9;
        broadcast_flag = 1'b1; broadcast_map = 6'd9; broadcast_val = 32'h77;
        rd_mapA = 6'd9;
        #1;
        chk("ab9_byp_val", rd_valA, 32'h77);
        chk("ab9_byp_ready", {31'd0, rd_readyA}, 32'd1);
        step();
        idle_inputs();
        #1;
        chk("ab9_ready", {31'd0, rd_readyA}, 32'd0);
        chk("ab9_val", rd_valA, 32'h77);
        chk("ab9_wake_flag", {31'd0, wakeup_flag}, 32'd1);
        chk("ab9_wake_map", {26'd0, wakeup_map}, 32'd9);
        chk("ab9_pending", {25'd0, pending_count}, 32'd1);

        // Alloc maps 1..10 (9 already pending), then flush with alloc 11 and broadcast 3.
        for (int m = 1; m <= 10; m++) begin
            alloc_flag = 1'b1; alloc_map = 6'(m);
            step();
        end
        idle_inputs();
        #1;
        chk("alloc10_pending", {25'd0, pending_count}, 32'd10);
        chk("alloc10_wake_off", {31'd0, wakeup_flag}, 32'd0);
        flush = 1'b1;
        alloc_flag = 1'b1; alloc_map = 6'd11;
        broadcast_flag = 1'b1; broadcast_map = 6'd3; broadcast_val = 32'hAA;
        step();
        idle_inputs();
        rd_mapA = 6'd3; rd_mapB = 6'd11;
        #1;
        chk("flush_pending", {25'd0, pending_count}, 32'd0);
        chk("flush_val3", rd_valA, 32'hAA);
        chk("flush_ready3", {31'd0, rd_readyA}, 32'd1);
        chk("flush_ready11", {31'd0, rd_readyB}, 32'd1);
        chk("flush_wake_flag", {31'd0, wakeup_flag}, 32'd1);
        chk("flush_wake_map", {26'd0, wakeup_map}, 32'd3);
        chk("flush_wake_val", wakeup_val, 32'hAA);
        rd_mapA = 6'd9; rd_mapB = 6'd7;
        #1;
        chk("flush_ready9", {31'd0, rd_readyA}, 32'd1);
        chk("flush_ready7", {31'd0, rd_readyB}, 32'd1);

        // Alloc 20, then alloc 21 with broadcast 30, then reset mid-cycle.
        alloc_flag = 1'b1; alloc_map = 6'd20;
        step();
        alloc_flag = 1'b1; alloc_map = 6'd21;
        broadcast_flag = 1'b1; broadcast_map = 6'd30; broadcast_val = 32'h55;
        step();
        idle_inputs();
        rd_mapA = 6'd20; rd_mapB = 6'd21;
        #1;
        chk("pre_rst_pending", {25'd0, pending_count}, 32'd2);
        chk("pre_rst_wake", {31'd0, wakeup_flag}, 32'd1);
        chk("pre_rst_ready20", {31'd0, rd_readyA}, 32'd0);
        #1 RESET = 1'b0;
        #1;
        chk("mid_rst_wake", {31'd0, wakeup_flag}, 32'd0);
        chk("mid_rst_wake_val", wakeup_val, 32'd0);
        chk("mid_rst_pending", {25'd0, pending_count}, 32'd0);
        chk("mid_rst_ready20", {31'd0, rd_readyA}, 32'd1);
        rd_mapA = 6'd30;
        #1;
        chk("mid_rst_val30", rd_valA, 32'd0);
        step();
        RESET = 1'b1;
        step();
        rd_mapA = 6'd20; rd_mapB = 6'd21;
        #1;
        chk("post_rst_ready20", {31'd0, rd_readyA}, 32'd1);
        chk("post_rst_ready21", {31'd0, rd_readyB}, 32'd1);
        chk("post_rst_pending", {25'd0, pending_count}, 32'd0);

        // Allocate every nonzero entry: count tops out at 63 and stays there.
        for (int m = 1; m <= 63; m++) begin
            alloc_flag = 1'b1; alloc_map = 6'(m);
            step();
        end
        alloc_flag = 1'b1; alloc_map = 6'd0;
        step();
        idle_inputs();
        #1;
        chk("full_pending", {25'd0, pending_count}, 32'd63);
        chk("full_le63", {31'd0, (pending_count <= 7'd63)}, 32'd1);
        alloc_flag = 1'b1; alloc_map = 6'd1;
        step();
        idle_inputs();
        #1;
        chk("realloc_pending", {25'd0, pending_count}, 32'd63);
        rd_mapA = 6'd0; rd_mapB = 6'd63;
        #1;
        chk("full_ready0", {31'd0, rd_readyA}, 32'd1);
        chk("full_ready63", {31'd0, rd_readyB}, 32'd0);

        // Broadcast and alloc on different maps: net count unchanged.
        broadcast_flag = 1'b1; broadcast_map = 6'd40; broadcast_val = 32'h4040;
        step();
        idle_inputs();
        #1;
        chk("dec_pending", {25'd0, pending_count}, 32'd62);
        broadcast_flag = 1'b1; broadcast_map = 6'd41; broadcast_val = 32'h4141;
        alloc_flag = 1'b1; alloc_map = 6'd40;
        step();
        idle_inputs();
        #1;
        chk("net0_pending", {25'd0, pending_count}, 32'd62);
        chk("net0_wake_map", {26'd0, wakeup_map}, 32'd41);

        // Broadcast to an already-ready entry: wakeup, no decrement.
        broadcast_flag = 1'b1; broadcast_map = 6'd41; broadcast_val = 32'h9999;
        step();
        idle_inputs();
        rd_mapA = 6'd41;
        #1;
        chk("rdy_bc_pending", {25'd0, pending_count}, 32'd62);
        chk("rdy_bc_wake", {31'd0, wakeup_flag}, 32'd1);
        chk("rdy_bc_val", rd_valA, 32'h9999);
        step();
        chk("pulse_end", {31'd0, wakeup_flag}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
